dpram_port_arbiter: RTL and testbench
=====================================

Name: dpram_port_arbiter

Overview:
- Shares one port of the dual-port RAM between NUM_REQ requesters, e.g. CPU load/store and the SPI slave DMA path.
- Arbitration is round-robin. The winner's command is multiplexed onto the RAM port.
- The block tracks the 1-cycle synchronous read latency and returns read data with a per-requester valid strobe.
- Sits between the requesters and the MEM side of one RAM port.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 8, RAM address width.
- DATA_WIDTH, 32, RAM data width.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req_i  in  NUM_REQ  request, one per requester; held until granted.
- req_we_i  in  NUM_REQ  1 = write, 0 = read, per requester.
- req_addr_i  in  NUM_REQ x ADDR_WIDTH  packed address per requester.
- req_wdata_i  in  NUM_REQ x DATA_WIDTH  packed write data per requester.
- gnt_o  out  NUM_REQ  one-hot grant; the command is accepted in this cycle.
- rvalid_o  out  NUM_REQ  one-hot read-data-valid.
- rdata_o  out  DATA_WIDTH  read data, shared by all requesters; qualified by rvalid_o.
- ram_en_o  out  1  to RAM en.
- ram_we_o  out  1  to RAM we.
- ram_addr_o  out  ADDR_WIDTH  to RAM addr.
- ram_wdata_o  out  DATA_WIDTH  to RAM wdata.
- ram_rdata_i  in  DATA_WIDTH  from RAM rdata; valid 1 cycle after a read.

Behaviour:
- Reset (rst_n = 0 at a clock edge):
  - ptr <= 0; rd_pending <= 0; rd_owner <= 0.
  - Counters (optional feature) <= 0.
- Outputs during reset and after it:
  - gnt_o and the ram_* outputs are combinational and are forced to 0 while rst_n = 0.
  - rvalid_o = 0 and rdata_o = 0 in the cycle after reset.
- Arbitration, combinational each cycle:
  - Search req_i starting at index ptr, wrapping NUM_REQ-1 -> 0.
  - The first set bit wins; gnt_o = onehot(winner).
  - No request: gnt_o = 0 and ram_en_o = 0.
- Zero-latency grant: a request is accepted in the cycle it is presented if it wins. One grant per cycle maximum.
- RAM drive on a grant:
  - ram_en_o = 1.
  - ram_we_o, ram_addr_o and ram_wdata_o come from the winner's slice.
  - When not granting, ram_we_o, ram_addr_o and ram_wdata_o = 0.
- Pointer:
  - On a grant to index w, ptr <= (w+1) mod NUM_REQ.
  - No grant: ptr holds.
  - ptr width is clog2(NUM_REQ), minimum 1 bit. Wrap is by explicit compare, not by natural overflow.
- Read return:
  - A read grant sets rd_pending <= 1 and rd_owner <= w at the edge.
  - In the following cycle: rvalid_o[rd_owner] = rd_pending and rdata_o = ram_rdata_i (combinational passthrough). rdata_o = 0 when not pending.
  - rd_pending clears after one cycle unless a new read is granted.
  - Back-to-back reads, one per cycle, are supported: a grant in the same cycle as a return is legal.
- Writes: no response is produced. gnt_o is the completion.
- Requester rules:
  - After gnt, the requester may drop req or present a new command in the next cycle.
  - Deasserting req without a grant is allowed (request withdrawn).
  - A requester may have only one read outstanding. The arbiter does not check this.
- Fairness: with all requesters continuously requesting, each is granted exactly once every NUM_REQ cycles.
- Reset mid-operation: a read granted in the cycle before reset produces no rvalid.

Optional Feature:
- DPRA_ARB_STATS_EN defined:
  - Adds output grant_cnt_o [NUM_REQ x 16]: per-requester saturating grant counters.
  - Adds output conflict_cnt_o [16]: counts cycles in which more than one request was pending. Saturating at 16'hFFFF.
  - All counters are cleared by reset.
- DPRA_ARB_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package dpram_arb_pkg holds:
  - Default width constants.
  - STAT_WIDTH = 16.
  - Function rr_pick(req, ptr): returns the winner index and a found flag.
- One natural sub-module, rr_arbiter: the request vector plus ptr in, one-hot grant out, owns the ptr register.
- The top level keeps the mux, the read-return tracking and the stats.

Test Plan:
- Single read: after reset, req0 read at addr 8'h10 where RAM holds 32'hDEADBEEF -> gnt_o = 2'b01 in the same cycle; next cycle rvalid_o = 2'b01 and rdata_o = 32'hDEADBEEF.
- Contention: req_i = 2'b11 held 6 cycles with ptr = 0 -> gnt_o sequence 01, 10, 01, 10, 01, 10.
- Write then read: req1 writes 32'h12345678 to addr 8'h3F, then reads addr 8'h3F -> rvalid_o = 2'b10 and rdata_o = 32'h12345678.
- Back-to-back reads: req0 and req1 reading addrs 1 and 2 alternately, each cycle -> rvalid_o toggles 01/10 every cycle, each with the correct data.
- Mid-operation reset: rst_n = 0 in the cycle after a read grant -> rvalid_o stays 0; then the first grant after reset goes to req0.
- Stats (macro defined): 10 contended cycles with 2 requesters -> conflict_cnt_o = 10, grant_cnt_o = {5, 5}.

Source files
------------

// File: rtl/dpram_arb_pkg.sv
// Shared constants, types and the round-robin pick function for dpram_port_arbiter.
package dpram_arb_pkg;

  localparam int DEF_NUM_REQ    = 2;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int STAT_WIDTH     = 16;

  // Upper bound on requesters; the pick function works on vectors of this size.
  localparam int MAX_REQ   = 8;
  localparam int MAX_IDX_W = 3;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } pick_t;

  // Scan req starting at ptr, wrapping at n-1 -> 0; the first set bit wins.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                    input logic [MAX_IDX_W-1:0] ptr,
                                    input int                   n);
    pick_t p;
    int    cand;
    p = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= n) cand = cand - n;
      if ((i < n) && !p.found && req[cand[MAX_IDX_W-1:0]]) begin
        p.found = 1'b1;
        p.idx   = cand[MAX_IDX_W-1:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/dpram_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: request vector in, one-hot grant out, owns the priority pointer.
module rr_arbiter
  import dpram_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               gnt_any_o,
  output logic [PTR_W-1:0]   gnt_idx_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  pick_t            pick;
  logic             unused_pick_bits;

  // Find the winner for this cycle; grants are suppressed while reset is asserted.
  always_comb begin
    pick      = rr_pick(MAX_REQ'(req_i), MAX_IDX_W'(ptr_q), NUM_REQ);
    gnt_any_o = rst_n & pick.found;
    gnt_idx_o = pick.idx[PTR_W-1:0];
    gnt_o     = gnt_any_o ? (NUM_REQ'(1) << gnt_idx_o) : '0;
  end

  assign unused_pick_bits = ^pick.idx;

  // Advance the pointer past the winner, wrapping by explicit compare.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any_o) begin
      if (gnt_idx_o == PTR_W'(NUM_REQ - 1)) ptr_d = '0;
      else                                   ptr_d = gnt_idx_o + PTR_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares one RAM port between NUM_REQ requesters with round-robin arbitration,
// muxes the winner onto the RAM and routes the 1-cycle read data back to its owner.
// Optional build macro DPRA_ARB_STATS_EN adds saturating grant/conflict counters.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter  int NUM_REQ    = DEF_NUM_REQ,
  parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  localparam int PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            req_we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic                          ram_en_o,
  output logic                          ram_we_o,
  output logic [ADDR_WIDTH-1:0]         ram_addr_o,
  output logic [DATA_WIDTH-1:0]         ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]         ram_rdata_i
`ifdef DPRA_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_WIDTH-1:0] grant_cnt_o,
  output logic [STAT_WIDTH-1:0]         conflict_cnt_o
`endif
);

  logic             gnt_any;
  logic [PTR_W-1:0] gnt_idx;
  logic             rd_pending_q, rd_pending_d;
  logic [PTR_W-1:0] rd_owner_q, rd_owner_d;
  logic             ret_en;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .gnt_o     (gnt_o),
    .gnt_any_o (gnt_any),
    .gnt_idx_o (gnt_idx)
  );

  // Multiplex the granted requester's command onto the RAM port; all zero when idle.
  always_comb begin
    ram_en_o    = gnt_any;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_o[i]) begin
        ram_we_o    = req_we_i[i];
        ram_addr_o  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_wdata_o = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A granted read arms the return for the next cycle; otherwise the pending flag drops.
  always_comb begin
    rd_pending_d = gnt_any & ~ram_we_o;
    rd_owner_d   = rd_owner_q;
    if (gnt_any && !ram_we_o) rd_owner_d = gnt_idx;
  end

  // Read-return tracking registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pending_q <= 1'b0;
      rd_owner_q   <= '0;
    end else begin
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  // Return strobe and passthrough data; a read caught by reset never reports back.
  always_comb begin
    ret_en   = rst_n & rd_pending_q;
    rvalid_o = ret_en ? (NUM_REQ'(1) << rd_owner_q) : '0;
    rdata_o  = ret_en ? ram_rdata_i : '0;
  end

`ifdef DPRA_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] grant_cnt_q [NUM_REQ];
  logic [STAT_WIDTH-1:0] grant_cnt_d [NUM_REQ];
  logic [STAT_WIDTH-1:0] conflict_cnt_q, conflict_cnt_d;
  logic                  multi_req;

  // Saturating increments: one per grant, and one per cycle with competing requests.
  always_comb begin
    multi_req      = ($countones(req_i) > 1);
    conflict_cnt_d = conflict_cnt_q;
    if (multi_req && (conflict_cnt_q != '1)) conflict_cnt_d = conflict_cnt_q + 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt_d[i] = grant_cnt_q[i];
      if (gnt_o[i] && (grant_cnt_q[i] != '1)) grant_cnt_d[i] = grant_cnt_q[i] + 1'b1;
    end
  end

  // Statistics registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conflict_cnt_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= grant_cnt_d[i];
    end
  end

  // Pack the per-requester counters onto the flat output.
  always_comb begin
    conflict_cnt_o = conflict_cnt_q;
    for (int i = 0; i < NUM_REQ; i++) grant_cnt_o[i*STAT_WIDTH +: STAT_WIDTH] = grant_cnt_q[i];
  end
`else
  // Statistics compiled out: no counters, no extra ports.
`endif

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Self-checking bench for dpram_port_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a cycle-level reference model and a shadow memory.
module tb_dpram_port_arbiter;

  localparam int N  = 2;
  localparam int AW = 8;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata, ram_wdata, ram_rdata;
  logic            ram_en, ram_we;
  logic [AW-1:0]   ram_addr;
`ifdef DPRA_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
  logic [15:0]     conflict_cnt;
`endif

  always #5 clk = ~clk;

  dpram_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .req_we_i    (we),
    .req_addr_i  (addr),
    .req_wdata_i (wdata),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .ram_en_o    (ram_en),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
`ifdef DPRA_ARB_STATS_EN
    ,
    .grant_cnt_o    (grant_cnt),
    .conflict_cnt_o (conflict_cnt)
`endif
  );

  // RAM stand-in with a preload path used while the arbiter is held in reset.
  logic [DW-1:0] mem [0:255];
  logic          pl_en;
  logic [AW-1:0] pl_a;
  logic [DW-1:0] pl_d;
  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  // Reference model state.
  int            m_ptr, m_owner, m_ccnt;
  bit            m_pend;
  logic [DW-1:0] m_rd;
  logic [DW-1:0] m_mem [0:255];
  int            m_gcnt [N];

  int n_vec = 0, n_err = 0;
  logic [N-1:0]  obs_gnt, obs_rv;
  logic [DW-1:0] obs_rd;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // One clock cycle: drive inputs, check all outputs against the model, advance the model.
  task automatic cyc(input logic r, input logic [N-1:0] rq, input logic [N-1:0] w,
                     input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
    int            win;
    logic [N-1:0]  e_g, e_rv;
    logic          e_we;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_wd, e_rd;
    rst_n = r; req = rq; we = w; addr = a; wdata = d;
    win = -1;
    if (r) for (int k = 0; k < N; k++) if (win < 0 && rq[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    e_g = '0; e_we = 1'b0; e_a = '0; e_wd = '0;
    if (win >= 0) begin
      e_g[win] = 1'b1; e_we = w[win]; e_a = a[win*AW +: AW]; e_wd = d[win*DW +: DW];
    end
    e_rv = '0; e_rd = '0;
    if (r && m_pend) begin e_rv[m_owner] = 1'b1; e_rd = m_rd; end
    @(negedge clk);
    obs_gnt = gnt; obs_rv = rvalid; obs_rd = rdata;
    chk("gnt",    64'(gnt),       64'(e_g));
    chk("en",     64'(ram_en),    64'(win >= 0));
    chk("we",     64'(ram_we),    64'(e_we));
    chk("addr",   64'(ram_addr),  64'(e_a));
    chk("wdata",  64'(ram_wdata), 64'(e_wd));
    chk("rvalid", 64'(rvalid),    64'(e_rv));
    chk("rdata",  64'(rdata),     64'(e_rd));
`ifdef DPRA_ARB_STATS_EN
    chk("conflict_cnt", 64'(conflict_cnt), 64'(m_ccnt));
    for (int i = 0; i < N; i++) chk("grant_cnt", 64'(grant_cnt[i*16 +: 16]), 64'(m_gcnt[i]));
`endif
    @(posedge clk);
    if (!r) begin
      m_ptr = 0; m_pend = 0; m_owner = 0; m_ccnt = 0;
      for (int i = 0; i < N; i++) m_gcnt[i] = 0;
    end else begin
      if ($countones(rq) > 1 && m_ccnt < 65535) m_ccnt++;
      if (win >= 0) begin
        m_ptr = (win + 1) % N;
        if (m_gcnt[win] < 65535) m_gcnt[win]++;
        if (w[win]) begin
          m_mem[e_a] = e_wd; m_pend = 0;
        end else begin
          m_pend = 1; m_owner = win; m_rd = m_mem[e_a];
        end
      end else m_pend = 0;
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    pl_en = 1'b1; pl_a = '0; pl_d = '0;
    m_ptr = 0; m_owner = 0; m_pend = 0; m_ccnt = 0; m_rd = '0;
    for (int i = 0; i < N; i++) m_gcnt[i] = 0;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) begin
      pl_a = AW'(i);
      pl_d = (i == 16) ? 32'hDEADBEEF : $urandom;
      m_mem[i] = pl_d;
      @(posedge clk); #1;
    end
    pl_en = 1'b0;

    // Reset state.
    cyc(1'b0, 2'b11, 2'b00, '0, '0);
    cyc(1'b0, 2'b00, 2'b00, '0, '0);

    // Single read from requester 0.
    cyc(1'b1, 2'b01, 2'b00, {8'h00, 8'h10}, '0);
    chk("tp_single_gnt", 64'(obs_gnt), 64'(2'b01));
    cyc(1'b1, 2'b00, 2'b00, '0, '0);
    chk("tp_single_rv", 64'(obs_rv), 64'(2'b01));
    chk("tp_single_rd", 64'(obs_rd), 64'(32'hDEADBEEF));

    // Contention with back-to-back reads of addresses 1 and 2.
    cyc(1'b0, 2'b00, 2'b00, '0, '0);
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 2'b11, 2'b00, {8'h02, 8'h01}, '0);
      chk("tp_rr_gnt", 64'(obs_gnt), (k % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
      if (k > 0) begin
        chk("tp_b2b_rv", 64'(obs_rv), (k % 2 == 1) ? 64'(2'b01) : 64'(2'b10));
        chk("tp_b2b_rd", 64'(obs_rd), (k % 2 == 1) ? 64'(m_mem[1]) : 64'(m_mem[2]));
      end
    end
    cyc(1'b1, 2'b00, 2'b00, '0, '0);
    chk("tp_b2b_last_rv", 64'(obs_rv), 64'(2'b10));

    // Write then read back from requester 1.
    cyc(1'b1, 2'b10, 2'b10, {8'h3F, 8'h00}, {32'h12345678, 32'h0});
    chk("tp_wr_gnt", 64'(obs_gnt), 64'(2'b10));
    cyc(1'b1, 2'b10, 2'b00, {8'h3F, 8'h00}, '0);
    cyc(1'b1, 2'b00, 2'b00, '0, '0);
    chk("tp_wr_rv", 64'(obs_rv), 64'(2'b10));
    chk("tp_wr_rd", 64'(obs_rd), 64'(32'h12345678));

    // Reset right after a read grant.
    cyc(1'b1, 2'b10, 2'b00, {8'h05, 8'h00}, '0);
    cyc(1'b0, 2'b01, 2'b00, '0, '0);
    chk("tp_rst_rv", 64'(obs_rv), 64'(2'b00));
    cyc(1'b1, 2'b11, 2'b00, {8'h04, 8'h03}, '0);
    chk("tp_rst_gnt", 64'(obs_gnt), 64'(2'b01));
    chk("tp_rst_rv2", 64'(obs_rv), 64'(2'b00));

`ifdef DPRA_ARB_STATS_EN
    // Ten contended cycles after reset.
    cyc(1'b0, 2'b00, 2'b00, '0, '0);
    for (int k = 0; k < 10; k++) cyc(1'b1, 2'b11, 2'b11, {8'h21, 8'h20}, {32'hA5A5A5A5, 32'h5A5A5A5A});
    cyc(1'b1, 2'b00, 2'b00, '0, '0);
    chk("tp_conflict", 64'(conflict_cnt), 64'd10);
    chk("tp_gcnt0", 64'(grant_cnt[15:0]), 64'd5);
    chk("tp_gcnt1", 64'(grant_cnt[31:16]), 64'd5);
`endif

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      logic          r;
      logic [N-1:0]  rq, w;
      logic [N*AW-1:0] a;
      logic [N*DW-1:0] d;
      r  = ($urandom_range(0, 39) != 0);
      rq = N'($urandom);
      w  = N'($urandom);
      a  = {2'b00, 6'($urandom), 2'b00, 6'($urandom)};
      d  = {$urandom, $urandom};
      cyc(r, rq, w, a, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
